e3_to_c2_serial: RTL

- Sequential decoder: converts a 4-digit excess-3 (E3) BCD magnitude plus a sign bit into an 11-bit two's-complement (C2) value.
- It is the reverse direction of the team's C2-to-E3 transform. It processes one digit per clock, MSD first, using a multiply-by-10 accumulator.
- Valid/ready handshakes on input and output. Flags invalid E3 digits and out-of-range magnitudes.

---
 rtl/e3_to_c2_serial_if.sv | 28 ++
 rtl/e3_to_c2_serial.sv | 130 +++++++++++++
 2 files changed

// File: rtl/e3_to_c2_serial_if.sv
// Handshake bundle for the serial E3-to-C2 decoder.
// Input side: in_valid/in_ready. Output side: out_valid/out_ready.
interface e3_to_c2_serial_if #(
  parameter int NDIG = 4,
  parameter int OW   = 11
);
  logic            in_valid;
  logic            in_ready;
  logic [4*NDIG-1:0] E3_in;
  logic            Sign_in;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   C2_out;
  logic            err_digit;
  logic            err_range;

  modport master (
    output in_valid, E3_in, Sign_in, out_ready,
    input  in_ready, out_valid, C2_out,
    input  err_digit, err_range
  );

  modport slave (
    input  in_valid, E3_in, Sign_in, out_ready,
    output in_ready, out_valid, C2_out,
    output err_digit, err_range
  );
endinterface

// File: rtl/e3_to_c2_serial.sv
// Serial excess-3 BCD to two's-complement decoder, MSD first.
// Define SAT_EN to saturate out-of-range results instead of zeroing.
module e3_to_c2_serial #(
  parameter int NDIG = 4,
  parameter int OW   = 11,
  parameter int AW   = 14
) (
  input logic clk,
  input logic rst_n,
  e3_to_c2_serial_if.slave bus
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW = 4 * NDIG;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [AW-1:0] LIM_P = AW'((2 ** (OW - 1)) - 1);
  localparam logic [OW-1:0] SAT_P = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SAT_N = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, CONV, FIX, DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] shreg;
  logic          sign_q;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          err_digit_q;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [OW-1:0] c2_r;
  logic          err_digit_r;
  logic          err_range_r;

  logic [3:0]    nib;
  logic          bad;
  logic [3:0]    dval;
  logic [AW-1:0] acc_nx;
  logic [AW-1:0] lim;
  logic          rng;
  logic [OW-1:0] c2_nx;

  assign nib  = shreg[SW-1 -: 4];
  assign bad  = (nib < 4'd3) || (nib > 4'd12);
  assign dval = bad ? 4'd0 : 4'(nib - 4'd3);
  assign acc_nx = (acc << 3) + (acc << 1)
                + {{(AW-4){1'b0}}, dval};
  assign lim = LIM_P + {{(AW-1){1'b0}}, sign_q};
  assign rng = !err_digit_q && (acc > lim);

  always_comb begin
    c2_nx = '0;
    if (err_digit_q) begin
      c2_nx = '0;
    end else if (rng) begin
`ifdef SAT_EN
      c2_nx = sign_q ? SAT_N : SAT_P;
`else
      c2_nx = '0;
`endif
    end else if (sign_q) begin
      c2_nx = -acc[OW-1:0];
    end else begin
      c2_nx = acc[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      sign_q      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      err_digit_q <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      c2_r        <= '0;
      err_digit_r <= 1'b0;
      err_range_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            shreg       <= bus.E3_in;
            sign_q      <= bus.Sign_in;
            acc         <= '0;
            cnt         <= '0;
            err_digit_q <= 1'b0;
            err_digit_r <= 1'b0;
            err_range_r <= 1'b0;
            c2_r        <= '0;
            in_ready_r  <= 1'b0;
            state       <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_nx;
          shreg <= shreg << 4;
          cnt   <= cnt + 1'b1;
          if (bad) err_digit_q <= 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          err_digit_r <= err_digit_q;
          err_range_r <= rng;
          c2_r        <= c2_nx;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.C2_out    = c2_r;
  assign bus.err_digit = err_digit_r;
  assign bus.err_range = err_range_r;

endmodule
